div_seq_ctrl: RTL and testbench

- Multi-cycle RV32M divide/remainder unit for the CPU execute stage.
- Contains one subtractor_32bit instance and uses it as a shared resource across every step: operand absolute value, 32 restoring-division iterations, and result sign correction.
- Fixed latency for normal operations; 1-cycle fast path for RISC-V special cases.
- Valid/ready handshake on both the request and response sides.

---
 rtl/div_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl - multi-cycle RV32M divide / remainder unit.
//
// One shared 32-bit subtractor is time-multiplexed over every step: operand
// absolute value, 32 restoring-division iterations and the final sign fix-up.
// Division by zero and signed overflow finish on a one-state fast path.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              synchronous abort of any in-flight operation
//   start_i / ready_o    request handshake (ready_o high only in IDLE)
//   op_i                 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i           rs1 value
//   divisor_i            rs2 value
//   valid_o / result_ready_i  response handshake
//   result_o             quotient (DIV/DIVU) or remainder (REM/REMU)
//   div_by_zero_o        divisor was zero, qualified by valid_o
// -----------------------------------------------------------------------------

// Plain 32-bit subtractor with borrow in/out; bout_o=1 when a_i < b_i + bin_i.
module subtractor_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        bin_i,
  output logic [31:0] diff_o,
  output logic        bout_o
);
  logic [32:0] w_full;

  assign w_full = {1'b0, a_i} - {1'b0, b_i} - {32'd0, bin_i};
  assign diff_o = w_full[31:0];
  assign bout_o = w_full[32];
endmodule

module div_seq_ctrl #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            start_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            div_by_zero_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS_A = 3'd1,
    S_ABS_B = 3'd2,
    S_CALC  = 3'd3,
    S_NEG_Q = 3'd4,
    S_NEG_R = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          r_state;
  logic            r_op_rem;     // 1: REM/REMU selects remainder
  logic [31:0]     r_q;          // dividend / quotient shift register
  logic [31:0]     r_d;          // divisor
  logic [31:0]     r_r;          // partial remainder
  logic            r_sa;         // dividend negative (signed ops only)
  logic            r_sb;         // divisor negative (signed ops only)
  logic            r_dbz;        // fast path was a divide by zero
  logic [4:0]      r_cnt;        // CALC iteration counter, ITER-1 down to 0
  logic            r_valid;
  logic [31:0]     r_result;
  logic            r_div_by_zero;

  logic            w_signed;
  logic            w_dbz;
  logic            w_ovf;
  logic [31:0]     w_trial;
  logic [31:0]     w_sub_a;
  logic [31:0]     w_sub_b;
  logic [31:0]     w_diff;
  logic            w_borrow;

  assign w_signed = ~op_i[0];
  assign w_dbz    = (divisor_i == 32'h0000_0000);
  assign w_ovf    = w_signed & (dividend_i == 32'h8000_0000) & (divisor_i == 32'hFFFF_FFFF);
  assign w_trial  = {r_r[30:0], r_q[31]};

  // Operand selection for the single shared subtractor, one pairing per state.
  always_comb begin
    w_sub_a = 32'h0000_0000;
    w_sub_b = 32'h0000_0000;
    case (r_state)
      S_ABS_A: begin
        w_sub_a = 32'h0000_0000;
        w_sub_b = r_q;
      end
      S_ABS_B: begin
        w_sub_a = 32'h0000_0000;
        w_sub_b = r_d;
      end
      S_CALC: begin
        w_sub_a = w_trial;
        w_sub_b = r_d;
      end
      S_NEG_Q: begin
        w_sub_a = 32'h0000_0000;
        w_sub_b = r_q;
      end
      S_NEG_R: begin
        w_sub_a = 32'h0000_0000;
        w_sub_b = r_r;
      end
      default: begin
        w_sub_a = 32'h0000_0000;
        w_sub_b = 32'h0000_0000;
      end
    endcase
  end

  subtractor_32bit u_sub (
    .a_i    (w_sub_a),
    .b_i    (w_sub_b),
    .bin_i  (1'b0),
    .diff_o (w_diff),
    .bout_o (w_borrow)
  );

  // Sequencer: accept, absolute values, restoring iterations, sign fix-up, respond.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_op_rem      <= 1'b0;
      r_q           <= 32'h0000_0000;
      r_d           <= 32'h0000_0000;
      r_r           <= 32'h0000_0000;
      r_sa          <= 1'b0;
      r_sb          <= 1'b0;
      r_dbz         <= 1'b0;
      r_cnt         <= 5'd0;
      r_valid       <= 1'b0;
      r_result      <= 32'h0000_0000;
      r_div_by_zero <= 1'b0;
    end else if (flush_i) begin
      // Abort wins over everything, including a same-cycle start.
      r_state       <= S_IDLE;
      r_valid       <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_op_rem <= op_i[1];
            r_d      <= divisor_i;
            r_sa     <= w_signed & dividend_i[31];
            r_sb     <= w_signed & divisor_i[31];
            if (w_dbz) begin
              // Quotient all ones, remainder is the dividend.
              r_q     <= 32'hFFFF_FFFF;
              r_r     <= dividend_i;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else if (w_ovf) begin
              // Most-negative / -1: quotient wraps to itself, remainder 0.
              r_q     <= 32'h8000_0000;
              r_r     <= 32'h0000_0000;
              r_dbz   <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_q     <= dividend_i;
              r_r     <= 32'h0000_0000;
              r_dbz   <= 1'b0;
              r_state <= S_ABS_A;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ABS_A: begin
          if (r_sa) begin
            r_q <= w_diff;
          end else begin
            r_q <= r_q;
          end
          r_state <= S_ABS_B;
        end
        S_ABS_B: begin
          if (r_sb) begin
            r_d <= w_diff;
          end else begin
            r_d <= r_d;
          end
          r_cnt   <= 5'(ITER - 1);
          r_state <= S_CALC;
        end
        S_CALC: begin
          // R[31] set means the 33-bit trial value certainly exceeds D.
          if (r_r[31] | ~w_borrow) begin
            r_r <= w_diff;
            r_q <= {r_q[30:0], 1'b1};
          end else begin
            r_r <= w_trial;
            r_q <= {r_q[30:0], 1'b0};
          end
          if (r_cnt == 5'd0) begin
            r_state <= S_NEG_Q;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_NEG_Q: begin
          if (r_sa ^ r_sb) begin
            r_q <= w_diff;
          end else begin
            r_q <= r_q;
          end
          r_state <= S_NEG_R;
        end
        S_NEG_R: begin
          // Remainder takes the sign of the dividend.
          if (r_sa) begin
            r_r <= w_diff;
          end else begin
            r_r <= r_r;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (r_valid) begin
            if (result_ready_i) begin
              r_valid       <= 1'b0;
              r_div_by_zero <= 1'b0;
              r_state       <= S_IDLE;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            // Register the response; it is held stable until consumed.
            r_valid       <= 1'b1;
            r_result      <= r_op_rem ? r_r : r_q;
            r_div_by_zero <= r_dbz;
            r_state       <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o       = (r_state == S_IDLE);
  assign valid_o       = r_valid;
  assign result_o      = r_result;
  assign div_by_zero_o = r_div_by_zero;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for div_seq_ctrl. Directed requests push their expected response
// (result, div-by-zero flag, latency) into a scoreboard queue; an independent
// monitor pops and compares whenever valid_o rises.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        flush_i;
  logic        start_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        valid_o;
  logic        result_ready_i;
  logic [31:0] result_o;
  logic        div_by_zero_o;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          seen = 1'b0;
  logic [31:0] last_res = 32'h0;

  div_seq_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .start_i        (start_i),
    .ready_o        (ready_o),
    .op_i           (op_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .valid_o        (valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .div_by_zero_o  (div_by_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure accept-to-valid latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each new response against the head of the scoreboard,
  // then check it stays stable while the consumer withholds result_ready_i.
  always @(negedge clk) begin
    if (!rst_ni) begin
      seen = 1'b0;
    end else if (valid_o) begin
      if (!seen) begin
        seen = 1'b1;
        last_res = result_o;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result_o, e.res);
          chk("div_by_zero", {31'd0, div_by_zero_o}, {31'd0, e.dbz});
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end else begin
        chk("result_stable", result_o, last_res);
      end
    end else begin
      seen = 1'b0;
    end
  end

  // Issue one request from a negedge; waits (bounded) for ready_o first.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic dbz, input int lat, input bit push);
    int n = 0;
    exp_t e;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk("ready_timeout", 32'd0, 32'd1);
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    if (push) begin
      e.res = exp;
      e.dbz = dbz;
      e.lat = lat;
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Wait (bounded) until every expected response was seen and the unit is idle.
  task automatic drain();
    int n = 0;
    while (!(sb.size() == 0 && ready_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit any_valid;
    rst_ni         = 1'b0;
    flush_i        = 1'b0;
    start_i        = 1'b0;
    op_i           = 2'b00;
    dividend_i     = 32'h0;
    divisor_i      = 32'h0;
    result_ready_i = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_dbz", {31'd0, div_by_zero_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);

    // Normal path: latency 37.
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 37, 1'b1);                    drain();
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 37, 1'b1);                     drain();
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 37, 1'b1);       drain();
    issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 37, 1'b1);       drain();
    issue(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 37, 1'b1);       drain();
    issue(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 37, 1'b1);               drain();
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 1'b0, 37, 1'b1);       drain();
    issue(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 37, 1'b1); drain();
    issue(OP_DIVU, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 37, 1'b1);               drain();
    issue(OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0, 37, 1'b1);      drain();
    issue(OP_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 37, 1'b1); drain();

    // Fast path: latency 1.
    issue(OP_DIVU, 32'd123, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 1'b1);              drain();
    issue(OP_REM,  32'd5, 32'd0, 32'd5, 1'b1, 1, 1'b1);                        drain();
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1'b1); drain();
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 1'b1);        drain();
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 37, 1'b1);       drain();

    // Backpressure: response held, start pulses ignored.
    result_ready_i = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 37, 1'b1);
    begin
      int n = 0;
      while (!valid_o && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
      chk("bp_ready", {31'd0, ready_o}, 32'd0);
      chk("bp_result", result_o, 32'd14);
      start_i    = i[0];
      op_i       = OP_DIVU;
      dividend_i = 32'd9;
      divisor_i  = 32'd3;
      @(negedge clk);
    end
    start_i        = 1'b0;
    result_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, valid_o}, 32'd0);
    chk("bp_release_ready", {31'd0, ready_o}, 32'd1);
    issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 37, 1'b1);                       drain();

    // Flush in CALC iteration 10 (no response expected).
    issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 0, 1'b0);
    repeat (11) @(negedge clk);
    flush_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    start_i = 1'b0;
    chk("flush_ready", {31'd0, ready_o}, 32'd1);
    any_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      any_valid = any_valid | valid_o;
      @(negedge clk);
    end
    chk("flush_no_valid", {31'd0, any_valid}, 32'd0);

    // Asynchronous reset mid-CALC.
    issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 0, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid_o}, 32'd0);
    chk("arst_result", result_o, 32'h0);
    chk("arst_ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 37, 1'b1);                       drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
